// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stage indices,
// mul/div sequencer states, default latencies and the control-word helper.
package pipe_stall_ctrl_pkg;

  localparam int STG_IFID  = 0;
  localparam int STG_IDEX  = 1;
  localparam int STG_EXMEM = 2;
  localparam int STG_MEMWB = 3;

  localparam int MUL_CYC_DEF = 2;
  localparam int DIV_CYC_DEF = 32;
  localparam int CNT_W_DEF   = 6;

  // One-hot masks per inter-stage register, in wait_stop/flush bit order.
  localparam logic [3:0] M_IFID  = 4'b0001 << STG_IFID;
  localparam logic [3:0] M_IDEX  = 4'b0001 << STG_IDEX;
  localparam logic [3:0] M_EXMEM = 4'b0001 << STG_EXMEM;
  localparam logic [3:0] M_MEMWB = 4'b0001 << STG_MEMWB;
  localparam logic [3:0] M_ALL   = M_IFID | M_IDEX | M_EXMEM | M_MEMWB;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  typedef struct packed {
    logic [3:0] wait_stop;
    logic [3:0] flush;
    logic       pc_en;
  } stall_ctrl_t;

  function automatic stall_ctrl_t mk_ctrl(input logic [3:0] hold,
                                          input logic [3:0] bubble,
                                          input logic       pc);
    stall_ctrl_t c;
    c.wait_stop = hold;
    c.flush     = bubble;
    c.pc_en     = pc;
    return c;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_md_seq.sv
// Multi-cycle mul/div sequencer: holds EX for the op latency using a
// down-counter, then reports the result valid until EX/MEM captures it.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   MD_IDLE | no op in flight; a new mul/div request stalls and starts
//   MD_BUSY | op in flight, cnt counts remaining stall cycles down to 1
//   MD_DONE | result valid, waiting for EX/MEM to capture (!mem_stall)
module pipe_stall_ctrl_md_seq
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MUL_CYC = MUL_CYC_DEF,
  parameter int DIV_CYC = DIV_CYC_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic md_req,
  input  logic md_is_div,
  input  logic mem_stall,
  input  logic exc_flush,
  output logic md_start,
  output logic ex_stall
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYC - 1);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;

  assign load_val = md_is_div ? DIV_LOAD : MUL_LOAD;
  assign md_start = (state == MD_IDLE) && md_req && !exc_flush && !mem_stall;
  assign ex_stall = ((state == MD_IDLE) && md_req) || (state == MD_BUSY);

  always_ff @(posedge clk) begin
    if (rst || exc_flush) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (md_start) begin
            cnt   <= load_val;
            state <= (load_val == '0) ? MD_DONE : MD_BUSY;
          end
        end
        MD_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= MD_DONE;
        end
        MD_DONE: begin
          // Result stays parked here under a MEM stall so it is not restarted.
          if (!mem_stall) state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central hazard/stall controller: per-register hold and bubble controls,
// PC enable, load-use detection and wrong-path fetch discard.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MUL_CYC = MUL_CYC_DEF,
  parameter int DIV_CYC = DIV_CYC_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inst_wait,
  input  logic       data_wait,
  input  logic       ex_md_req,
  input  logic       ex_md_is_div,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_redirect,
  input  logic       exc_flush,
  output logic [3:0] wait_stop,
  output logic [3:0] flush,
  output logic       pc_en,
  output logic       md_start,
  output logic       md_busy
);

  logic        mem_stall, ex_stall, id_stall, if_stall;
  logic        md_start_raw;
  logic        redirect_take;
  logic        discard;
  stall_ctrl_t ctrl;

  pipe_stall_ctrl_md_seq #(
    .MUL_CYC(MUL_CYC),
    .DIV_CYC(DIV_CYC),
    .CNT_W  (CNT_W)
  ) u_md_seq (
    .clk      (clk),
    .rst      (rst),
    .md_req   (ex_md_req),
    .md_is_div(ex_md_is_div),
    .mem_stall(mem_stall),
    .exc_flush(exc_flush),
    .md_start (md_start_raw),
    .ex_stall (ex_stall)
  );

  assign mem_stall = data_wait;
  assign id_stall  = ex_is_load && (ex_rd != 5'd0) &&
                     ((id_use_rs && (ex_rd == id_rs)) || (id_use_rt && (ex_rd == id_rt)));
  assign if_stall  = inst_wait || discard;

  always_comb begin
    ctrl          = mk_ctrl(4'b0000, 4'b0000, 1'b1);
    redirect_take = 1'b0;
    if (exc_flush) begin
      ctrl = mk_ctrl(4'b0000, M_ALL, 1'b1);
    end else if (mem_stall) begin
      ctrl = mk_ctrl(M_IFID | M_IDEX | M_EXMEM, M_MEMWB, 1'b0);
    end else if (ex_stall) begin
      ctrl = mk_ctrl(M_IFID | M_IDEX, M_EXMEM, 1'b0);
    end else if (ex_redirect) begin
      ctrl          = mk_ctrl(4'b0000, M_IFID | M_IDEX, 1'b1);
      redirect_take = 1'b1;
    end else if (id_stall) begin
      ctrl = mk_ctrl(M_IFID, M_IDEX, 1'b0);
    end else if (if_stall) begin
      ctrl = mk_ctrl(4'b0000, M_IFID, 1'b0);
    end
  end

  // A fetch still outstanding at a redirect belongs to the wrong path;
  // remember it so the instruction it eventually returns is bubbled.
  always_ff @(posedge clk) begin
    if (rst) begin
      discard <= 1'b0;
    end else if (exc_flush || redirect_take) begin
      discard <= inst_wait;
    end else if (discard && !inst_wait) begin
      discard <= 1'b0;
    end
  end

  assign wait_stop = rst ? 4'b0000 : ctrl.wait_stop;
  assign flush     = rst ? M_ALL   : ctrl.flush;
  assign pc_en     = !rst && ctrl.pc_en;
  assign md_start  = !rst && md_start_raw;
  assign md_busy   = !rst && ex_stall;

endmodule
